pwm_fade: RTL

PWM_FADE -- requirements
Module: pwm_fade

---
 rtl/pwm_fade.sv | 118 +++++++++++
 1 files changed

// File: rtl/pwm_fade.sv
// pwm_fade: walks a PWM level toward a target in steps of 1..8 counts.
// One step is taken every (rate+1) PWM periods. Each new level is presented
// with a one-cycle set_level strobe, and done pulses when the target is reached.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | level is held; waiting for start
//   RAMP  | fade in progress; period/rate counters time the next step
module pwm_fade #(
    parameter int PERIOD = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] target,
    input  logic [7:0] rate,
    input  logic [2:0] step_size,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] level,
    output logic       set_level,
    output logic       busy,
    output logic       done
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] period_cnt;
    logic [7:0]    rate_cnt;
    logic [7:0]    target_q;
    logic [7:0]    rate_q;
    logic [3:0]    delta_q;

    logic          period_wrap;
    logic          rate_wrap;
    logic          step_event;
    logic [8:0]    level_up;
    logic [8:0]    level_dn;
    logic [7:0]    level_next;

    assign period_wrap = (period_cnt == PERIOD_LAST);
    assign rate_wrap   = (rate_cnt == rate_q);
    assign step_event  = (state == RAMP) && period_wrap && rate_wrap;
    assign busy        = (state == RAMP);

    // Next level one step toward the target. The sums are 9 bits wide so an
    // overshoot past 255 or below 0 is visible and clamps to the target.
    always_comb begin
        level_up   = {1'b0, level} + {5'b0_0000, delta_q};
        level_dn   = {1'b0, level} - {5'b0_0000, delta_q};
        level_next = target_q;
        if (target_q > level) begin
            if (level_up < {1'b0, target_q}) begin
                level_next = level_up[7:0];
            end
        end else if (target_q < level) begin
            if (!level_dn[8] && (level_dn > {1'b0, target_q})) begin
                level_next = level_dn[7:0];
            end
        end
    end

    // Sequencer: stop beats start, start beats a coincident step, and level
    // is only ever written together with its set_level strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            level      <= 8'd0;
            set_level  <= 1'b0;
            done       <= 1'b0;
            period_cnt <= '0;
            rate_cnt   <= 8'd0;
            target_q   <= 8'd0;
            rate_q     <= 8'd0;
            delta_q    <= 4'd0;
        end else begin
            set_level <= 1'b0;
            done      <= 1'b0;
            if (stop) begin
                state <= IDLE;
            end else if (start) begin
                target_q   <= target;
                rate_q     <= rate;
                delta_q    <= {1'b0, step_size} + 4'd1;
                period_cnt <= '0;
                rate_cnt   <= 8'd0;
                if (target == level) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else begin
                    state <= RAMP;
                end
            end else if (state == RAMP) begin
                if (period_wrap) begin
                    period_cnt <= '0;
                    rate_cnt   <= rate_wrap ? 8'd0 : rate_cnt + 8'd1;
                end else begin
                    period_cnt <= period_cnt + 1'b1;
                end
                if (step_event) begin
                    level     <= level_next;
                    set_level <= 1'b1;
                    if (level_next == target_q) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
